// File: rtl/rr_pkt_sched.sv
// Packet-level round-robin scheduler for an AXI-Stream RX mux: one grant held per packet, released on tlast.
// Optional stall watchdog enabled with `define RR_PKT_SCHED_TIMEOUT_EN.
module rr_pkt_sched #(
  parameter int unsigned IF_COUNT  = 3,
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IF_COUNT-1:0]  s_axis_tvalid,
  input  logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 m_axis_tlast,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 en,
  output logic [IF_COUNT-1:0]  grant,
  output logic [31:0]          pkt_count,
  output logic                 timeout_pulse
);

  // Elaboration-time parameter sanity checks
  if (IF_COUNT < 1 || IF_COUNT > 16) begin : g_bad_if_count
    $error("rr_pkt_sched: IF_COUNT out of range");
  end
  if ((1 << SEL_WIDTH) < IF_COUNT || SEL_WIDTH < 1) begin : g_bad_sel_width
    $error("rr_pkt_sched: SEL_WIDTH too narrow");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("rr_pkt_sched: TIMEOUT must be at least 2");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [SEL_WIDTH-1:0]   last_q, last_d;
  logic [IF_COUNT-1:0]    grant_q, grant_d;
  logic                   en_q, en_d;
  logic [31:0]            pkt_count_q, pkt_count_d;

  logic                   hs_c;
  logic                   eop_c;
  logic                   to_fire_c;
  logic                   found_c;
  logic [SEL_WIDTH-1:0]   win_c;
  int                     best_c;
  int                     dist_c;

  assign hs_c  = m_axis_tvalid & m_axis_tready;
  assign eop_c = hs_c & m_axis_tlast;

  // Pick the requester closest after last_q in circular order
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    best_c  = int'(IF_COUNT);
    dist_c  = 0;
    for (int j = 0; j < int'(IF_COUNT); j++) begin
      dist_c = (j + int'(IF_COUNT) - 1 - int'(last_q)) % int'(IF_COUNT);
      if (s_axis_tvalid[j] && (dist_c < best_c)) begin
        best_c  = dist_c;
        win_c   = SEL_WIDTH'(j);
        found_c = 1'b1;
      end
    end
  end

  always_comb begin
    logic rearb;
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    grant_d     = grant_q;
    en_d        = en_q;
    pkt_count_d = pkt_count_q;
    rearb       = 1'b0;

    case (state_q)
      ST_IDLE: rearb = 1'b1;
      ST_GRANT: begin
        if (eop_c) begin
          pkt_count_d = pkt_count_q + 32'd1;
          rearb       = 1'b1;
        end else if (to_fire_c) begin
          rearb = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rearb) begin
      if (found_c) begin
        state_d = ST_GRANT;
        sel_d   = win_c;
        last_d  = win_c;
        grant_d = IF_COUNT'(1) << win_c;
        en_d    = 1'b1;
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
        en_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      last_q      <= SEL_WIDTH'(IF_COUNT - 1);
      grant_q     <= '0;
      en_q        <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      en_q        <= en_d;
      pkt_count_q <= pkt_count_d;
    end
  end

`ifdef RR_PKT_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic             tpulse_q, tpulse_d;

  assign to_fire_c = (state_q == ST_GRANT) && !hs_c && (stall_q == CNT_W'(TIMEOUT - 1));

  // Stall counter only advances on handshake-free GRANT cycles; any release restarts it
  always_comb begin
    stall_d  = '0;
    tpulse_d = to_fire_c;
    if ((state_q == ST_GRANT) && !hs_c && !to_fire_c) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      tpulse_q <= 1'b0;
    end else begin
      stall_q  <= stall_d;
      tpulse_q <= tpulse_d;
    end
  end

  assign timeout_pulse = tpulse_q;
`else
  assign to_fire_c     = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign sel       = sel_q;
  assign en        = en_q;
  assign grant     = grant_q;
  assign pkt_count = pkt_count_q;

endmodule
